// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: CPU request/response and memory-port signals of the burst controller
interface mem_burst_ctrl_if #(
  parameter int DW = 10,
  parameter int AW = 14,
  parameter int MAXBURST = 3,
  parameter int LW = $clog2(MAXBURST + 1)
) ();
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [AW-1:0]          req_addr;
  logic [LW-1:0]          req_len;
  logic [DW*MAXBURST-1:0] req_wdata;
  logic                   rsp_valid;
  logic [DW*MAXBURST-1:0] rsp_rdata;
  logic [AW-1:0]          m_addr;
  logic [DW-1:0]          m_indata;
  logic                   m_write;
  logic                   m_read;
  logic [DW-1:0]          m_outdata;
  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, m_outdata,
    input  req_ready, rsp_valid, rsp_rdata, m_addr, m_indata, m_write, m_read
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, m_outdata,
    output req_ready, rsp_valid, rsp_rdata, m_addr, m_indata, m_write, m_read
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: sequences one multi-word request into per-cycle memory accesses and packs read bursts
module mem_burst_ctrl #(
  parameter int DW = 10,
  parameter int AW = 14,
  parameter int MAXBURST = 3,
  parameter int RD_LAT = 1,
  localparam int LW = $clog2(MAXBURST + 1)
) (
  input logic clk,
  input logic rst,
  mem_burst_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_len, r_idx, w_len;
  logic [MAXBURST-1:0][DW-1:0] r_wdata, r_rdata;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0][LW-1:0] r_pidx;
  logic w_accept, w_issue, w_last_cap;
  assign w_len = bus.req_len == '0 ? LW'(1) :
                 32'(bus.req_len) > MAXBURST ? LW'(MAXBURST) : bus.req_len;
  assign w_accept = r_state == IDLE && bus.req_valid;
  assign w_issue = r_state == READ && r_idx < r_len;
  // reads return in issue order, so the last slot emerging means the burst is complete
  assign w_last_cap = r_pv[RD_LAT-1] && r_pidx[RD_LAT-1] == r_len - LW'(1);
  assign bus.rsp_rdata = r_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_accept ? (bus.req_write ? WRITE : READ) : IDLE;
      WRITE: w_next = r_idx == r_len - LW'(1) ? RESP : WRITE;
      READ:  w_next = w_last_cap ? RESP : READ;
      RESP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = r_state == IDLE;
    bus.rsp_valid = r_state == RESP;
    bus.m_write = r_state == WRITE;
    bus.m_read = w_issue;
    bus.m_addr = (r_state == WRITE || w_issue) ? r_addr : '0;
    bus.m_indata = r_state == WRITE ? r_wdata[r_idx] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_len <= '0;
      r_idx <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_pv <= '0;
      r_pidx <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pidx[0] <= r_idx;
      for (int j = RD_LAT - 1; j > 0; j--) begin
        r_pv[j] <= r_pv[j-1];
        r_pidx[j] <= r_pidx[j-1];
      end
      if (w_accept) begin
        r_addr <= bus.req_addr;
        r_len <= w_len;
        r_idx <= '0;
        r_wdata <= bus.req_wdata;
        if (!bus.req_write) r_rdata <= '0;
      end else if (r_state == WRITE || w_issue) begin
        r_addr <= r_addr + AW'(1);
        r_idx <= r_idx + LW'(1);
      end
      if (r_pv[RD_LAT-1]) r_rdata[r_pidx[RD_LAT-1]] <= bus.m_outdata;
    end
  end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: scoreboard bench with random bursts on a default instance plus a directed wide-parameter instance
module tb_mem_burst_ctrl;
  localparam int DW = 10, AW = 14, MB = 3, LAT = 1, LW = $clog2(MB + 1);
  localparam int DW2 = 16, AW2 = 8, MB2 = 4, LAT2 = 3, LW2 = $clog2(MB2 + 1);
  logic clk = 0, rst = 1;
  int cyc = 0, total = 0, bad = 0;
  bit sb_on = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_burst_ctrl_if #(.DW(DW), .AW(AW), .MAXBURST(MB)) ba ();
  mem_burst_ctrl_if #(.DW(DW2), .AW(AW2), .MAXBURST(MB2)) bb ();
  mem_burst_ctrl #(.DW(DW), .AW(AW), .MAXBURST(MB), .RD_LAT(LAT)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  mem_burst_ctrl #(.DW(DW2), .AW(AW2), .MAXBURST(MB2), .RD_LAT(LAT2)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));
  function automatic int init_val(input int x);
    return (x * 40503) ^ 32'h5A5A;
  endfunction
  // memory environments: unwritten words read as init_val(address)
  logic [DW-1:0] mem_a [2**AW];
  bit wr_a [2**AW];
  logic [DW-1:0] dl_a [LAT];
  always @(posedge clk) begin
    if (ba.m_write) begin
      mem_a[ba.m_addr] <= ba.m_indata;
      wr_a[ba.m_addr] <= 1'b1;
    end
    dl_a[0] <= ba.m_read ? (wr_a[ba.m_addr] ? mem_a[ba.m_addr] : DW'(init_val(int'(ba.m_addr)))) : DW'($urandom);
    for (int j = LAT - 1; j > 0; j--) dl_a[j] <= dl_a[j-1];
  end
  assign ba.m_outdata = dl_a[LAT-1];
  logic [DW2-1:0] mem_b [2**AW2];
  bit wr_b [2**AW2];
  logic [DW2-1:0] dl_b [LAT2];
  always @(posedge clk) begin
    if (bb.m_write) begin
      mem_b[bb.m_addr] <= bb.m_indata;
      wr_b[bb.m_addr] <= 1'b1;
    end
    dl_b[0] <= bb.m_read ? (wr_b[bb.m_addr] ? mem_b[bb.m_addr] : DW2'(init_val(int'(bb.m_addr)))) : DW2'($urandom);
    for (int j = LAT2 - 1; j > 0; j--) dl_b[j] <= dl_b[j-1];
  end
  assign bb.m_outdata = dl_b[LAT2-1];
  // reference model: sparse memory image plus expected access and response queues
  logic [DW-1:0] ref_a [logic [AW-1:0]];
  logic [DW2-1:0] ref_b [logic [AW2-1:0]];
  typedef struct { int cyc; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
  typedef struct { int cyc; logic [DW*MB-1:0] rdata; } rsp_t;
  acc_t acc_q [$];
  rsp_t rsp_q [$];
  acc_t m_e;
  rsp_t m_r;
  logic [DW*MB-1:0] last_rd = '0;
  int exp_rdy = 0;
  bit rdy_pend = 0;
  function automatic logic [DW-1:0] ref_rd_a(input logic [AW-1:0] x);
    return ref_a.exists(x) ? ref_a[x] : DW'(init_val(int'(x)));
  endfunction
  function automatic logic [DW2-1:0] ref_rd_b(input logic [AW2-1:0] x);
    return ref_b.exists(x) ? ref_b[x] : DW2'(init_val(int'(x)));
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask
  always @(negedge clk) if (sb_on) begin
    chk("a_excl", 64'(ba.m_write & ba.m_read), 64'(0));
    if (ba.m_write || ba.m_read) begin
      if (acc_q.size() == 0) begin
        total++; bad++;
        $display("FAIL a_access: unexpected access addr %0h at cycle %0d, want none", ba.m_addr, cyc);
      end else begin
        m_e = acc_q.pop_front();
        chk("a_acc_cycle", 64'(cyc), 64'(m_e.cyc));
        chk("a_acc_kind", 64'(ba.m_write), 64'(m_e.wr));
        chk("a_addr", 64'(ba.m_addr), 64'(m_e.addr));
        chk("a_wdata", 64'(ba.m_indata), 64'(m_e.data));
      end
    end else chk("a_idle_bus", 64'({ba.m_addr, ba.m_indata}), 64'(0));
    if (ba.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL a_rsp: unexpected rsp_valid at cycle %0d, want none", cyc);
      end else begin
        m_r = rsp_q.pop_front();
        chk("a_rsp_cycle", 64'(cyc), 64'(m_r.cyc));
        chk("a_rdata", 64'(ba.rsp_rdata), 64'(m_r.rdata));
      end
    end
  end
  task automatic req_a(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] ln,
                       input logic [DW*MB-1:0] wd, input int gap);
    int n = 0, l;
    logic [AW-1:0] ai;
    logic [DW*MB-1:0] rd = '0;
    forever begin
      @(negedge clk);
      if (ba.req_ready) begin
        if (rdy_pend) begin
          chk("a_ready_cycle", 64'(cyc), 64'(exp_rdy));
          rdy_pend = 0;
        end
        if (gap == 0) break;
        gap--;
        ba.req_valid = 0;
      end else begin
        ba.req_valid = 1'($urandom);
        ba.req_write = 1'($urandom);
        ba.req_addr = AW'($urandom);
        ba.req_len = LW'($urandom);
        ba.req_wdata = (DW*MB)'({$urandom, $urandom});
        if (++n > 200) begin
          total++; bad++;
          $display("FAIL a_ready_timeout: req_ready low for %0d cycles, want at most %0d", n, MB + LAT + 2);
          finish_now();
        end
      end
    end
    ba.req_valid = 1;
    ba.req_write = wr;
    ba.req_addr = a;
    ba.req_len = ln;
    ba.req_wdata = wd;
    l = ln == 0 ? 1 : (int'(ln) > MB ? MB : int'(ln));
    for (int i = 0; i < l; i++) begin
      ai = a + AW'(i);
      if (wr) ref_a[ai] = wd[i*DW +: DW];
      else rd[i*DW +: DW] = ref_rd_a(ai);
      acc_q.push_back('{cyc + 1 + i, wr, ai, wr ? wd[i*DW +: DW] : '0});
    end
    if (!wr) last_rd = rd;
    rsp_q.push_back('{cyc + l + 1 + (wr ? 0 : LAT), last_rd});
    exp_rdy = cyc + l + 2 + (wr ? 0 : LAT);
    rdy_pend = 1;
  endtask
  task automatic go_b(input bit wr, input logic [AW2-1:0] a, input logic [LW2-1:0] ln, input logic [DW2*MB2-1:0] wd);
    chk("b_accept_ready", 64'(bb.req_ready), 64'(1));
    bb.req_valid = 1;
    bb.req_write = wr;
    bb.req_addr = a;
    bb.req_len = ln;
    bb.req_wdata = wd;
  endtask
  task automatic watch_b(input bit wr, input logic [AW2-1:0] a, input int l,
                         input logic [DW2*MB2-1:0] wd, input logic [DW2*MB2-1:0] exp_rd);
    int lat = wr ? 0 : LAT2;
    logic [AW2-1:0] ea;
    for (int k = 1; k <= l + lat + 2; k++) begin
      @(negedge clk);
      if (k == 1) bb.req_valid = 0;
      ea = k <= l ? a + AW2'(k - 1) : '0;
      chk("b_write", 64'(bb.m_write), 64'(wr && k <= l));
      chk("b_read", 64'(bb.m_read), 64'(!wr && k <= l));
      chk("b_addr", 64'(bb.m_addr), 64'(ea));
      chk("b_wdata", 64'(bb.m_indata), (wr && k <= l) ? 64'(wd[(k-1)*DW2 +: DW2]) : 64'(0));
      chk("b_rsp_valid", 64'(bb.rsp_valid), 64'(k == l + lat + 1));
      chk("b_ready", 64'(bb.req_ready), 64'(k == l + lat + 2));
      if (k == l + lat + 1) chk("b_rdata", 64'(bb.rsp_rdata), 64'(exp_rd));
    end
  endtask
  initial begin
    #500000;
    total++; bad++;
    $display("FAIL watchdog: simulation did not complete");
    finish_now();
  end
  initial begin
    int n;
    logic [AW-1:0] ra;
    logic [AW2-1:0] ab;
    logic [DW2*MB2-1:0] wdb, rdb;
    ba.req_valid = 0; ba.req_write = 0; ba.req_addr = '0; ba.req_len = '0; ba.req_wdata = '0;
    bb.req_valid = 0; bb.req_write = 0; bb.req_addr = '0; bb.req_len = '0; bb.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ba.req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(ba.rsp_valid), 64'(0));
    chk("rst_rdata", 64'(ba.rsp_rdata), 64'(0));
    chk("rst_m_write", 64'(ba.m_write), 64'(0));
    chk("rst_m_read", 64'(ba.m_read), 64'(0));
    chk("rst_m_addr", 64'(ba.m_addr), 64'(0));
    chk("rst_m_indata", 64'(ba.m_indata), 64'(0));
    chk("rst_b_ready", 64'(bb.req_ready), 64'(1));
    rst = 0;
    @(negedge clk);
    ba.req_valid = 1; ba.req_write = 1; ba.req_addr = 14'h0010; ba.req_len = 2'd3;
    ba.req_wdata = {10'h3FF, 10'h2AA, 10'h155};
    @(negedge clk);
    ba.req_valid = 0;
    chk("abort_w0_en", 64'(ba.m_write), 64'(1));
    chk("abort_w0_addr", 64'(ba.m_addr), 64'h10);
    chk("abort_w0_data", 64'(ba.m_indata), 64'h155);
    @(negedge clk);
    chk("abort_w1_addr", 64'(ba.m_addr), 64'h11);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("abort_m_write", 64'(ba.m_write), 64'(0));
    chk("abort_ready", 64'(ba.req_ready), 64'(1));
    chk("abort_m_addr", 64'(ba.m_addr), 64'(0));
    @(negedge clk);
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(ba.rsp_valid), 64'(0));
    end
    chk("abort_mem0", 64'(mem_a[14'h10]), 64'h155);
    chk("abort_mem1", 64'(mem_a[14'h11]), 64'h2AA);
    chk("abort_mem2_untouched", 64'(wr_a[14'h12]), 64'(0));
    ref_a[14'h10] = 10'h155;
    ref_a[14'h11] = 10'h2AA;
    sb_on = 1;
    req_a(1, 14'h0010, 2'd3, {10'h3FF, 10'h2AA, 10'h155}, 0);
    req_a(0, 14'h0010, 2'd3, '0, 0);
    req_a(0, 14'h0011, 2'd0, '0, 0);
    req_a(0, 14'h0011, LW'(7), '0, 0);
    req_a(1, 14'h3FFF, 2'd2, {10'h000, 10'h123, 10'h0C5}, 0);
    req_a(0, 14'h3FFF, 2'd2, '0, 1);
    repeat (150) begin
      ra = $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'(14'h3FF8 + AW'($urandom_range(0, 15)));
      req_a(1'($urandom), ra, LW'($urandom), (DW*MB)'({$urandom, $urandom}), $urandom_range(0, 2));
    end
    @(negedge clk);
    ba.req_valid = 0;
    n = 0;
    while ((rsp_q.size() != 0 || acc_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_drain", 64'(rsp_q.size() + acc_q.size()), 64'(0));
    rdb = '0;
    for (int i = 0; i < 4; i++) begin
      ab = AW2'(8'h40 + i);
      rdb[i*DW2 +: DW2] = ref_rd_b(ab);
    end
    go_b(0, 8'h40, 3'd4, '0);
    watch_b(0, 8'h40, 4, '0, rdb);
    wdb = {$urandom, $urandom};
    go_b(1, 8'hFE, 3'd4, wdb);
    for (int i = 0; i < 4; i++) begin
      ab = AW2'(8'hFE + i);
      ref_b[ab] = wdb[i*DW2 +: DW2];
    end
    watch_b(1, 8'hFE, 4, wdb, rdb);
    go_b(0, 8'hFE, 3'd4, '0);
    watch_b(0, 8'hFE, 4, '0, wdb);
    finish_now();
  end
endmodule
